// File: rtl/clarvi_sliced_alu_seq_pkg.sv
// Shared types for the sliced multi-cycle ALU: operation codes, the
// inter-slice chain record, FSM states and the slice-count helper.
package clarvi_sliced_alu_seq_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_OR, ALU_AND, ALU_SL, ALU_SRL, ALU_SRA
    } alu_op_t;

    typedef struct packed {
        logic carry;
        logic lt;
        logic eq;
    } alu_chain_t;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} alu_state_t;

    // Word ops only cover bits 31:0; a slice at least 32 wide handles them in one step.
    function automatic int n_slices(input int xlen, input int slice_w, input logic word);
        if (!word) return xlen / slice_w;
        return (slice_w >= 32) ? 1 : 32 / slice_w;
    endfunction

endpackage

// File: rtl/clarvi_sliced_alu_seq_if.sv
// Request/response handshake bundle between the issuing stage and the sliced ALU.
interface clarvi_sliced_alu_seq_if #(parameter int XLEN = 64);
    import clarvi_sliced_alu_seq_pkg::*;

    logic            in_valid;
    logic            in_ready;
    alu_op_t         in_op;
    logic            in_word;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    modport master (
        output in_valid, in_op, in_word, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_word, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/clarvi_sliced_alu_seq_slice.sv
// One SLICE_W-bit step of the ALU: arithmetic, compare chaining, logic ops
// and the funnel shift that builds a shifted slice from two source slices.
module clarvi_sliced_alu_seq_slice
    import clarvi_sliced_alu_seq_pkg::*;
#(
    parameter  int SLICE_W = 16,
    localparam int RW      = $clog2(SLICE_W)
) (
    input  alu_op_t            op,
    input  logic               top,
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic [SLICE_W-1:0] sl_hi,
    input  logic [SLICE_W-1:0] sl_lo,
    input  logic [SLICE_W-1:0] sr_hi,
    input  logic [SLICE_W-1:0] sr_lo,
    input  logic [RW-1:0]      r,
    input  alu_chain_t         chain_in,
    output logic [SLICE_W-1:0] result,
    output alu_chain_t         chain_out
);

    logic [SLICE_W:0]     sum;
    logic [2*SLICE_W-1:0] lsh;
    logic [2*SLICE_W-1:0] rsh;
    logic                 slice_lt;
    logic                 slice_eq;

    assign sum = {1'b0, a_i} + {1'b0, (op == ALU_SUB) ? ~b_i : b_i}
               + (SLICE_W+1)'(chain_in.carry);
    assign lsh = {sl_hi, sl_lo} << r;
    assign rsh = {sr_hi, sr_lo} >> r;
    assign slice_eq = (a_i == b_i);
    // Only the most significant slice of a signed compare carries the sign.
    assign slice_lt = (top && op == ALU_SLT) ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);

    always_comb begin
        result    = '0;
        chain_out = chain_in;
        case (op)
            ALU_ADD, ALU_SUB: begin
                result          = sum[SLICE_W-1:0];
                chain_out.carry = sum[SLICE_W];
            end
            ALU_SLT, ALU_SLTU: begin
                chain_out.lt = slice_lt | (slice_eq & chain_in.lt);
                chain_out.eq = slice_eq & chain_in.eq;
            end
            ALU_XOR:          result = a_i ^ b_i;
            ALU_OR:           result = a_i | b_i;
            ALU_AND:          result = a_i & b_i;
            ALU_SL:           result = lsh[2*SLICE_W-1:SLICE_W];
            ALU_SRL, ALU_SRA: result = rsh[SLICE_W-1:0];
            default:          result = 'x;
        endcase
    end

endmodule

// File: rtl/clarvi_sliced_alu_seq.sv
// Multi-cycle integer ALU processing one slice per cycle, LSB first, with
// word mode, flush and a held result handshake.
module clarvi_sliced_alu_seq
    import clarvi_sliced_alu_seq_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int SLICE_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    clarvi_sliced_alu_seq_if.slave bus,
    output logic                   busy
);

    localparam int NS = XLEN / SLICE_W;
    localparam int IW = $clog2(NS) + 1;
    localparam int RW = $clog2(SLICE_W);
    localparam int AW = $clog2(XLEN);

    alu_state_t         state_q, state_d;
    alu_op_t            op_q;
    logic               word_q;
    logic [XLEN-1:0]    a_q, b_q, result_q;
    logic [IW-1:0]      idx_q;
    alu_chain_t         chain_q, chain_d;

    logic               accept, sext_in, last;
    logic [XLEN-1:0]    a_in, b_in, merged, finished;
    int                 n_cur, i_cur, q;
    logic [AW-1:0]      amt;
    logic [RW-1:0]      r;
    logic [SLICE_W-1:0] fill, a_i, b_i, sl_hi, sl_lo, sr_hi, sr_lo, slice_res;

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
        return {{(XLEN-32){s & v[31]}}, v};
    endfunction

    // Source slices outside the active operand width read as the shift fill.
    function automatic logic [SLICE_W-1:0] src(input logic [XLEN-1:0] v, input int j,
                                               input int n, input logic [SLICE_W-1:0] f);
        if (j < 0 || j >= n) return f;
        return SLICE_W'(v >> (j * SLICE_W));
    endfunction

    assign bus.in_ready   = (state_q == ST_IDLE) && !flush;
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_result = result_q;
    assign busy           = (state_q != ST_IDLE);
    assign accept         = bus.in_valid && bus.in_ready;

    // Word operands are pre-extended so every slice width sees a plain 64-bit problem.
    assign sext_in = bus.in_word && (bus.in_op == ALU_SLT || bus.in_op == ALU_SRA);
    assign a_in    = bus.in_word ? ext32(bus.in_a[31:0], sext_in) : bus.in_a;
    assign b_in    = bus.in_word ? ext32(bus.in_b[31:0], sext_in) : bus.in_b;

    assign n_cur = n_slices(XLEN, SLICE_W, word_q);
    assign i_cur = int'(idx_q);
    assign last  = (i_cur == n_cur - 1);
    assign amt   = b_q[AW-1:0] & (word_q ? AW'(31) : {AW{1'b1}});
    assign q     = int'(amt >> RW);
    assign r     = amt[RW-1:0];
    assign fill  = (op_q == ALU_SRA) ? {SLICE_W{a_q[XLEN-1]}} : '0;

    assign a_i   = SLICE_W'(a_q >> (i_cur * SLICE_W));
    assign b_i   = SLICE_W'(b_q >> (i_cur * SLICE_W));
    assign sl_hi = src(a_q, i_cur - q,     n_cur, fill);
    assign sl_lo = src(a_q, i_cur - q - 1, n_cur, fill);
    assign sr_lo = src(a_q, i_cur + q,     n_cur, fill);
    assign sr_hi = src(a_q, i_cur + q + 1, n_cur, fill);

    clarvi_sliced_alu_seq_slice #(.SLICE_W(SLICE_W)) u_slice (
        .op        (op_q),
        .top       (last),
        .a_i       (a_i),
        .b_i       (b_i),
        .sl_hi     (sl_hi),
        .sl_lo     (sl_lo),
        .sr_hi     (sr_hi),
        .sr_lo     (sr_lo),
        .r         (r),
        .chain_in  (chain_q),
        .result    (slice_res),
        .chain_out (chain_d)
    );

    assign merged = (result_q & ~(XLEN'({SLICE_W{1'b1}}) << (i_cur * SLICE_W)))
                  | (XLEN'(slice_res) << (i_cur * SLICE_W));

    always_comb begin
        finished = merged;
        if (op_q == ALU_SLT || op_q == ALU_SLTU)
            finished = {{(XLEN-1){1'b0}}, chain_d.lt};
        else if (word_q)
            finished = {{(XLEN-32){merged[31]}}, merged[31:0]};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)        state_d = ST_BUSY;
            ST_BUSY: if (last)          state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q     <= ALU_ADD;
            word_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            chain_q  <= '0;
        end else if (!flush) begin
            if (accept) begin
                op_q    <= bus.in_op;
                word_q  <= bus.in_word;
                a_q     <= a_in;
                b_q     <= b_in;
                idx_q   <= '0;
                chain_q <= {bus.in_op == ALU_SUB, 1'b0, 1'b1};
            end else if (state_q == ST_BUSY) begin
                result_q <= last ? finished : merged;
                chain_q  <= chain_d;
                idx_q    <= last ? '0 : idx_q + IW'(1);
            end
        end
    end

endmodule
